// File: rtl/bitbakery_serial_pkg.sv
// Shared constants and state encodings for the BitBakery serial game link.
// Latency: n/a (declarations only).
// Backpressure: n/a; the packet FSM encoding is also decoded by the transmitter side via db_estado.
package bitbakery_serial_pkg;

  localparam logic [7:0] HEADER_BYTE  = 8'hFF;
  localparam logic [7:0] TRAILER_BYTE = 8'hFF;
  localparam int         PAYLOAD_LEN  = 11;

  // Packet FSM encoding, visible on db_estado.
  typedef enum logic [3:0] {
    ESPERA_HDR = 4'd0,
    PAYLOAD    = 4'd1,
    ESPERA_TRL = 4'd2
  } pkt_state_t;

  // Byte receiver FSM encoding.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rx_serial_8E1.sv
// 8E1 byte receiver: 2-flop synchronizer, mid-bit sampling, parity and stop check.
// Latency: strobe 1 cycle after the stop-bit sample (line to sampler adds 2 cycles).
// Backpressure: none; strobes are single-cycle and must be consumed when they fire.
module rx_serial_8E1 import bitbakery_serial_pkg::*; #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dados_ascii,
  output logic       byte_ok,
  output logic       byte_par_err,
  output logic       byte_frm_err,
  output logic       rx_idle
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic [1:0]    sync_vld;
  logic          line;
  logic          armed;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          tick, half_tick, par_ok;
  logic          ok_nxt, par_nxt, frm_nxt;

  assign line      = sync[1];
  assign tick      = (cnt == BIT_LAST);
  assign half_tick = (cnt == HALF_LAST);
  assign par_ok    = ~(^shreg ^ par_bit);
  assign rx_idle   = (state == RX_IDLE);

  // Synchronizer; sync_vld marks when sync[1] holds a real sample rather than its reset value,
  // so a line held low through reset is not mistaken for a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync     <= 2'b11;
      sync_vld <= 2'b00;
    end else begin
      sync     <= {sync[0], entrada_serial};
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // Next-state and end-of-frame classification.
  always_comb begin
    state_nxt = state;
    ok_nxt    = 1'b0;
    par_nxt   = 1'b0;
    frm_nxt   = 1'b0;
    case (state)
      RX_IDLE:   if (armed && !line) state_nxt = RX_START;
      RX_START:  if (half_tick) state_nxt = line ? RX_IDLE : RX_DATA;
      RX_DATA:   if (tick && bit_idx == 3'd7) state_nxt = RX_PARITY;
      RX_PARITY: if (tick) state_nxt = RX_STOP;
      RX_STOP: begin
        if (tick) begin
          state_nxt = RX_IDLE;
          ok_nxt    = par_ok && line;
          par_nxt   = !par_ok;
          frm_nxt   = par_ok && !line;
        end
      end
      default:   state_nxt = RX_IDLE;
    endcase
  end

  // State register, bit timing, data shift and registered strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RX_IDLE;
      armed        <= 1'b0;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      dados_ascii  <= '0;
      byte_ok      <= 1'b0;
      byte_par_err <= 1'b0;
      byte_frm_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      byte_ok      <= ok_nxt;
      byte_par_err <= par_nxt;
      byte_frm_err <= frm_nxt;

      // A start needs a fresh falling edge: arm only after seeing a real idle-high line.
      if (state == RX_IDLE) begin
        if (state_nxt == RX_START) armed <= 1'b0;
        else if (line && sync_vld[1]) armed <= 1'b1;
      end

      if (state == RX_IDLE || state_nxt != state || (state == RX_DATA && tick)) cnt <= '0;
      else cnt <= cnt + 1'b1;

      if (state != RX_DATA) bit_idx <= '0;
      else if (tick) bit_idx <= bit_idx + 1'b1;

      if (state == RX_DATA && tick)   shreg   <= {line, shreg[7:1]};
      if (state == RX_PARITY && tick) par_bit <= line;
      if (state == RX_STOP && tick)   dados_ascii <= shreg;
    end
  end

endmodule

// File: rtl/bitbakery_serial_rx.sv
// Game-link receiver: reassembles FF/D0/D1/D2/map[8]/FF packets from 8E1 bytes.
// Latency: outputs and pronto register 1 cycle after the trailer byte strobe.
// Backpressure: none; aborted packets (parity, framing, trailer, idle timeout) are dropped.
module bitbakery_serial_rx import bitbakery_serial_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [7:0]  D0,
  output logic [7:0]  D1,
  output logic [7:0]  D2,
  output logic [63:0] map_obstacles,
  output logic        pronto,
  output logic        erro_paridade,
  output logic        erro_pacote,
  output logic [3:0]  db_estado
);

  localparam int            LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW       = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LIMIT - 1);
  localparam logic [3:0]    IDX_LAST = 4'(PAYLOAD_LEN - 1);

  logic [7:0]               dados;
  logic                     byte_ok, byte_par_err, byte_frm_err, rx_idle;
  pkt_state_t               state, state_nxt;
  logic [3:0]               idx;
  logic [PAYLOAD_LEN*8-1:0] shadow;
  logic [TW-1:0]            tcnt;
  logic                     timeout, store, latch;
  logic                     pronto_nxt, par_nxt, pac_nxt;

  rx_serial_8E1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dados_ascii    (dados),
    .byte_ok        (byte_ok),
    .byte_par_err   (byte_par_err),
    .byte_frm_err   (byte_frm_err),
    .rx_idle        (rx_idle)
  );

  assign timeout   = (state != ESPERA_HDR) && rx_idle && (tcnt == TO_LAST);
  assign db_estado = state;

  // Packet sequencing: header hunt, payload fill, trailer check, aborts.
  always_comb begin
    state_nxt  = state;
    store      = 1'b0;
    latch      = 1'b0;
    pronto_nxt = 1'b0;
    par_nxt    = 1'b0;
    pac_nxt    = 1'b0;
    case (state)
      ESPERA_HDR: begin
        par_nxt = byte_par_err;
        if (byte_ok && dados == HEADER_BYTE) state_nxt = PAYLOAD;
      end
      PAYLOAD, ESPERA_TRL: begin
        if (byte_par_err) begin
          par_nxt   = 1'b1;
          pac_nxt   = 1'b1;
          state_nxt = ESPERA_HDR;
        end else if (byte_frm_err || timeout) begin
          pac_nxt   = 1'b1;
          state_nxt = ESPERA_HDR;
        end else if (byte_ok) begin
          if (state == PAYLOAD) begin
            store = 1'b1;
            if (idx == IDX_LAST) state_nxt = ESPERA_TRL;
          end else if (dados == TRAILER_BYTE) begin
            latch      = 1'b1;
            pronto_nxt = 1'b1;
            state_nxt  = ESPERA_HDR;
          end else begin
            pac_nxt   = 1'b1;
            state_nxt = ESPERA_HDR;
          end
        end
      end
      default: state_nxt = ESPERA_HDR;
    endcase
  end

  // State, shadow fill, idle timeout and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ESPERA_HDR;
      idx           <= '0;
      shadow        <= '0;
      tcnt          <= '0;
      D0            <= '0;
      D1            <= '0;
      D2            <= '0;
      map_obstacles <= '0;
      pronto        <= 1'b0;
      erro_paridade <= 1'b0;
      erro_pacote   <= 1'b0;
    end else begin
      state         <= state_nxt;
      pronto        <= pronto_nxt;
      erro_paridade <= par_nxt;
      erro_pacote   <= pac_nxt;

      // Shadow is wiped while hunting for a header, so an abort never leaks stale bytes.
      if (state == ESPERA_HDR) begin
        idx    <= '0;
        shadow <= '0;
      end else if (store) begin
        shadow[{idx, 3'b000} +: 8] <= dados;
        idx                        <= idx + 1'b1;
      end

      // Idle timer only advances between bytes of a packet in progress.
      if (state == ESPERA_HDR || byte_ok || byte_par_err || byte_frm_err || timeout) tcnt <= '0;
      else if (rx_idle) tcnt <= tcnt + 1'b1;

      if (latch) {map_obstacles, D2, D1, D0} <= shadow;
    end
  end

endmodule

// File: doc/bitbakery_serial_rx.md
# bitbakery_serial_rx

Receiver for the BitBakery game link: deserializes 8E1 frames from the serial line, checks parity and stop bit, and reassembles the 13-byte game packet (0xFF header, D0, D1, D2, eight map_obstacles bytes LSB-byte first, 0xFF trailer) emitted by the serial transmitter data flow. Sits directly downstream of the transmitter, on the receiving board. Presents the last good packet on registered outputs with a one-cycle `pronto` strobe.

## Interface
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be ≥ 4
- TIMEOUT_BITS, 40, bit periods allowed between end of one byte and start of the next inside a packet
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (low = reset)
- entrada_serial  in  1  serial line, idle high
- D0, D1, D2  out  8 each  last valid packet bytes 1..3
- map_obstacles  out  64  last valid packet bytes 4..11; byte 4 → [7:0], byte 11 → [63:56]
- pronto  out  1  one-cycle pulse: new packet latched
- erro_paridade  out  1  one-cycle pulse: byte with bad even parity
- erro_pacote  out  1  one-cycle pulse: packet aborted (framing, trailer, timeout)
- db_estado  out  4  packet FSM state, debug

## Operation
- Input passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized signal.
- Byte receiver FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: wait for synchronized line = 0.
  - START: wait CLKS_PER_BIT/2 (floor) cycles, resample; if 1, false start, back to IDLE, no output.
  - DATA: 8 samples, CLKS_PER_BIT apart, LSB first.
  - PARITY: one sample; parity OK when XOR of 8 data bits and parity bit = 0.
  - STOP: one sample; must be 1 else framing error.
  - On leaving STOP: one-cycle internal `byte_ok` (parity OK, stop = 1), `byte_par_err`, or `byte_frm_err`. Parity error takes precedence when both apply.
- Packet FSM: ESPERA_HDR, PAYLOAD, ESPERA_TRL.
  - ESPERA_HDR: `byte_ok` with 0xFF → PAYLOAD, index = 0, timeout cleared; any other byte ignored silently.
  - PAYLOAD: each `byte_ok` stored in shadow register at index (0..10, 0xFF legal as data); after index 10 → ESPERA_TRL.
  - ESPERA_TRL: `byte_ok` 0xFF → copy shadow to outputs, pulse `pronto`, → ESPERA_HDR; other value → pulse `erro_pacote`, → ESPERA_HDR.
  - In PAYLOAD/ESPERA_TRL: `byte_par_err` → `erro_paridade` and `erro_pacote` same cycle, abort; `byte_frm_err` → `erro_pacote`, abort; idle timeout → `erro_pacote`, abort. Abort discards shadow and returns to ESPERA_HDR.
  - In ESPERA_HDR, `byte_par_err` pulses `erro_paridade` only.
- Outputs change only on a valid trailer; all 88 data bits update on the same edge.

## Timing
- Reset values: D0 = D1 = D2 = 0, map_obstacles = 0, pronto = erro_paridade = erro_pacote = 0, db_estado = ESPERA_HDR (0), both FSMs idle, shadow cleared.
- Reset deassertion mid-frame: receiver returns to IDLE; a partially received frame is lost; a line still low waits in IDLE for a fresh falling edge (no re-trigger on level).
- Latency: synchronizer 2 cycles. Byte strobe is 1 cycle after the stop sample. Outputs and `pronto` are registered 1 cycle after the trailer strobe.
- Timeout counter runs only in PAYLOAD/ESPERA_TRL while the byte receiver is IDLE. It resets on each byte strobe and fires at TIMEOUT_BITS·CLKS_PER_BIT cycles.
- Back-to-back frames (stop bit immediately followed by start) are accepted.

## Structure
- Package `bitbakery_serial_pkg`: HEADER_BYTE = 8'hFF, TRAILER_BYTE = 8'hFF, PAYLOAD_LEN = 11, packet FSM state encodings (shared with the transmitter control unit for db_estado decoding).
- Sub-module `rx_serial_8E1`: synchronizer plus byte receiver FSM, outputs `dados_ascii[7:0]`, `byte_ok`, `byte_par_err`, `byte_frm_err`; mirrors `tx_serial_8E1`.
- Top holds packet FSM, index counter, shadow register, timeout counter.

## Test plan
Benches use CLKS_PER_BIT = 8, TIMEOUT_BITS = 4.
- Reset, then send FF 12 34 56 01 02 03 04 05 06 07 08 FF → one `pronto`; D0 = 0x12, D1 = 0x34, D2 = 0x56, map_obstacles = 0x0807060504030201; no error pulses.
- Same packet with byte 6 parity flipped → `erro_paridade` + `erro_pacote` once, no `pronto`, outputs keep previous values; then a valid packet → `pronto`.
- Payload containing 0xFF values (D0 = FF, map all FF) plus trailer 0x00 → `erro_pacote`, outputs unchanged. Resend with trailer FF → `pronto`, map_obstacles = 0xFFFF_FFFF_FFFF_FFFF.
- 3-cycle low glitch on idle line → no byte strobe, no pulses; stop bit driven 0 inside a packet → `erro_pacote` only.
- Header + 5 bytes, then line idle > 32 cycles → `erro_pacote` once, db_estado = 0. Reset asserted mid-byte → all outputs 0 immediately, line-low-after-reset produces no byte.
